// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB over one shared
// memory port. Requests use a valid/ready handshake with an optional wait
// timeout. The unit counts retired instructions and latches illegal-instruction
// and memory-timeout traps.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode/funct3/funct7 IR fields, valid from DECODE onward
//   branch_taken        datapath comparator result for the current branch
//   mem_ready           memory completes the outstanding request this cycle
//   mem_req/mem_we/mem_addr_sel  memory request, store, address select (0 PC, 1 ALU reg)
//   ir_write, reg_write, wb_sel  IR load, register write, write-back mux
//   alu_src_a/alu_src_b/alu_ctl/imm_type  ALU operand muxes, operation, immediate format
//   pc_write, pc_src    PC update strobe and source mux
//   instret             retired-instruction count (wraps)
//   trap, trap_cause    halted flag and cause (01 illegal, 10 memory timeout)
//   state               current FSM state
// MEM_TIMEOUT must be below 2**TO_W; 0 disables the timeout.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [2:0]       imm_type,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       trap_cause_q, trap_cause_d;

  logic             retire_c;
  logic             legal_c;
  logic             alt_c;
  logic             timeout_hit_c;
  logic [TO_W-1:0]  wait_inc_c;
  logic [3:0]       alu_dec_c;

  assign alt_c         = (funct7 == F7_ALT);
  assign timeout_hit_c = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_W'(MEM_TIMEOUT));
  assign wait_inc_c    = (wait_cnt_q == {TO_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + TO_W'(1);

  // Legal opcode set; R-type also restricts funct7 (alt form only for ADD/SUB and SRL/SRA).
  always_comb begin
    legal_c = 1'b0;
    unique case (opcode)
      OP_R:      legal_c = (funct7 == F7_BASE) ||
                           (alt_c && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_IMM,
      OP_LOAD,
      OP_STORE,
      OP_BRANCH,
      OP_JAL,
      OP_JALR,
      OP_LUI,
      OP_AUIPC:  legal_c = 1'b1;
      default:   legal_c = 1'b0;
    endcase
  end

  // ALU operation for R/I arithmetic; SUB exists only in R-type, SRA/SRAI in both.
  always_comb begin
    alu_dec_c = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_dec_c = ((opcode == OP_R) && alt_c) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec_c = ALU_SLL;
      3'b010:  alu_dec_c = ALU_SLT;
      3'b011:  alu_dec_c = ALU_SLTU;
      3'b100:  alu_dec_c = ALU_XOR;
      3'b101:  alu_dec_c = alt_c ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec_c = ALU_OR;
      default: alu_dec_c = ALU_AND;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    trap_cause_d = trap_cause_q;
    retire_c     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctl      = ALU_AND;
    imm_type     = IMM_I;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    trap         = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout_hit_c) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_inc_c;
        end
      end

      // Precompute PC + B-immediate while the instruction is checked.
      ST_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b01;
        imm_type  = IMM_B;
        alu_ctl   = ALU_ADD;
        if (legal_c) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end
      end

      ST_EXECUTE: begin
        state_d   = ST_WB;
        alu_ctl   = ALU_ADD;
        alu_src_b = 2'b01;
        unique case (opcode)
          OP_R: begin
            alu_ctl   = alu_dec_c;
            alu_src_b = 2'b00;
          end
          OP_IMM:   alu_ctl = alu_dec_c;
          OP_LOAD:  state_d = ST_MEM;
          OP_STORE: begin
            imm_type = IMM_S;
            state_d  = ST_MEM;
          end
          OP_BRANCH: begin
            alu_ctl   = ALU_SUB;
            alu_src_b = 2'b00;
            pc_write  = 1'b1;
            pc_src    = branch_taken ? PC_BRANCH : PC_PLUS4;
            retire_c  = 1'b1;
            state_d   = ST_FETCH;
          end
          OP_JAL: begin
            imm_type  = IMM_J;
            alu_src_a = 1'b1;
          end
          OP_LUI:   imm_type = IMM_U;
          OP_AUIPC: begin
            imm_type  = IMM_U;
            alu_src_a = 1'b1;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (timeout_hit_c) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_inc_c;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire_c  = 1'b1;
        state_d   = ST_FETCH;
        unique case (opcode)
          OP_LOAD:         wb_sel = WB_MEM;
          OP_JAL, OP_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_JUMP;
          end
          OP_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
      end

      ST_TRAP: trap = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

  assign instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;

  // State and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      wait_cnt_q   <= '0;
      instret_q    <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign state      = state_q;
  assign instret    = instret_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: table vectors, hand sequences for
// handshake/timeout/trap corners, and randomized instruction streams checked
// cycle by cycle against an instruction-level reference model.
module tb_multicycle_control_unit;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 6;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          branch_taken;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_write, reg_write;
  logic [1:0]    wb_sel;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [3:0]    alu_ctl;
  logic [2:0]    imm_type;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic [CW-1:0] instret;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [2:0]    state;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .imm_type(imm_type), .pc_write(pc_write), .pc_src(pc_src),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic [2:0] imm_type;
    logic       pc_write;
    logic [1:0] pc_src;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       tk;
    logic [3:0] alu;
    logic [1:0] wb;
    logic [1:0] pc;
    int         ncyc;
  } vec_t;

  vec_t          vecs[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] m_instret;

  logic [3:0] alu_base [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1000,
                               4'b0011, 4'b0101, 4'b0001, 4'b0000};
  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  function automatic int cls_of(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    case (op)
      7'b0110011: return ((f7 == 7'd0) ||
                          (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) ? C_R : C_ILL;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_ref(int c, logic [2:0] f3, logic [6:0] f7);
    logic alt;
    alt = (f7 == 7'b0100000);
    if (f3 == 3'd5 && alt) return 4'b1001;
    if (f3 == 3'd0 && alt && c == C_R) return 4'b0110;
    return alu_base[f3];
  endfunction

  function automatic out_t blank(logic [2:0] st);
    out_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic out_t fetch_exp(logic rdy);
    out_t o;
    o = blank(3'd0);
    o.mem_req  = 1'b1;
    o.ir_write = rdy;
    return o;
  endfunction

  function automatic out_t decode_exp();
    out_t o;
    o = blank(3'd1);
    o.alu_src_a = 1'b1;
    o.alu_src_b = 2'b01;
    o.imm_type  = 3'b010;
    o.alu_ctl   = 4'b0010;
    return o;
  endfunction

  function automatic out_t exec_exp(int c, logic [2:0] f3, logic [6:0] f7, logic tk);
    out_t o;
    o = blank(3'd2);
    o.alu_ctl   = 4'b0010;
    o.alu_src_b = 2'b01;
    case (c)
      C_R:     begin o.alu_ctl = alu_ref(c, f3, f7); o.alu_src_b = 2'b00; end
      C_I:     o.alu_ctl = alu_ref(c, f3, f7);
      C_ST:    o.imm_type = 3'b001;
      C_BR:    begin
                 o.alu_ctl = 4'b0110; o.alu_src_b = 2'b00;
                 o.pc_write = 1'b1; o.pc_src = tk ? 2'b01 : 2'b00;
               end
      C_JAL:   begin o.imm_type = 3'b100; o.alu_src_a = 1'b1; end
      C_LUI:   o.imm_type = 3'b011;
      C_AUIPC: begin o.imm_type = 3'b011; o.alu_src_a = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t mem_exp(int c, logic rdy);
    out_t o;
    o = blank(3'd3);
    o.mem_req      = 1'b1;
    o.mem_addr_sel = 1'b1;
    o.mem_we       = (c == C_ST);
    o.pc_write     = (c == C_ST) && rdy;
    return o;
  endfunction

  function automatic out_t wb_exp(int c);
    out_t o;
    o = blank(3'd4);
    o.reg_write = 1'b1;
    o.pc_write  = 1'b1;
    if (c == C_LD) o.wb_sel = 2'b01;
    if (c == C_LUI) o.wb_sel = 2'b11;
    if (c == C_JAL || c == C_JALR) begin o.wb_sel = 2'b10; o.pc_src = 2'b10; end
    return o;
  endfunction

  function automatic out_t trap_exp(logic [1:0] cause);
    out_t o;
    o = blank(3'd7);
    o.trap       = 1'b1;
    o.trap_cause = cause;
    return o;
  endfunction

  // One clock: drive, settle, compare all outputs and the count, then advance.
  task automatic cyc(input string nm, input logic rdy, input logic tk,
                     input out_t e, output out_t a);
    mem_ready    = rdy;
    branch_taken = tk;
    #2;
    a = {state, trap, trap_cause, mem_req, mem_we, mem_addr_sel, ir_write,
         reg_write, wb_sel, alu_src_a, alu_src_b, alu_ctl, imm_type, pc_write, pc_src};
    n_vec++;
    if (a !== e || instret !== m_instret) begin
      n_err++;
      $display("FAIL %s: got outputs %h instret %0d, expected outputs %h instret %0d",
               nm, a, instret, e, m_instret);
    end
    @(posedge clk);
    #1;
    if (e.pc_write) m_instret = m_instret + CW'(1);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'($urandom);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_instret = '0;
  endtask

  // Runs one instruction with fdel/mdel wait cycles before mem_ready.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic tk, input int fdel,
                           input int mdel, output int ncyc, output logic [3:0] o_alu,
                           output logic [1:0] o_wb, output logic [1:0] o_pc);
    int   c;
    out_t a;
    c = cls_of(op, f3, f7);
    ncyc = 0; o_alu = '0; o_wb = '0; o_pc = '0;
    for (int k = 0; k <= fdel; k++) begin
      if (k < fdel) begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end else begin
        opcode = op; funct3 = f3; funct7 = f7;
      end
      cyc({nm, "_fetch"}, k == fdel, 1'($urandom), fetch_exp(k == fdel), a);
      ncyc++;
    end
    cyc({nm, "_decode"}, 1'($urandom), 1'($urandom), decode_exp(), a);
    ncyc++;
    if (c == C_ILL) return;
    cyc({nm, "_exec"}, 1'($urandom), tk, exec_exp(c, f3, f7, tk), a);
    ncyc++;
    o_alu = a.alu_ctl;
    if (c == C_BR) begin o_wb = a.wb_sel; o_pc = a.pc_src; return; end
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k <= mdel; k++) begin
        cyc({nm, "_mem"}, k == mdel, 1'($urandom), mem_exp(c, k == mdel), a);
        ncyc++;
        if (c == C_ST && k == mdel) begin o_wb = a.wb_sel; o_pc = a.pc_src; return; end
      end
    end
    cyc({nm, "_wb"}, 1'($urandom), 1'($urandom), wb_exp(c), a);
    ncyc++;
    o_wb = a.wb_sel;
    o_pc = a.pc_src;
  endtask

  task automatic addv(input string nm, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic tk, input logic [3:0] alu,
                      input logic [1:0] wb, input logic [1:0] pc, input int ncyc);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.tk = tk;
    v.alu = alu; v.wb = wb; v.pc = pc; v.ncyc = ncyc;
    vecs.push_back(v);
  endtask

  task automatic expect_trap(input string nm, input logic [1:0] cause, input int n);
    out_t a;
    for (int k = 0; k < n; k++) begin
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      cyc(nm, 1'($urandom), 1'($urandom), trap_exp(cause), a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] ra;
    logic [1:0] rw, rp;
    out_t       a;

    addv("add",   7'b0110011, 3'b000, 7'b0000000, 1'b0, 4'b0010, 2'b00, 2'b00, 4);
    addv("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0, 4'b0110, 2'b00, 2'b00, 4);
    addv("sra",   7'b0110011, 3'b101, 7'b0100000, 1'b0, 4'b1001, 2'b00, 2'b00, 4);
    addv("sltu",  7'b0110011, 3'b011, 7'b0000000, 1'b0, 4'b1000, 2'b00, 2'b00, 4);
    addv("and",   7'b0110011, 3'b111, 7'b0000000, 1'b0, 4'b0000, 2'b00, 2'b00, 4);
    addv("addi",  7'b0010011, 3'b000, 7'b0100000, 1'b0, 4'b0010, 2'b00, 2'b00, 4);
    addv("srai",  7'b0010011, 3'b101, 7'b0100000, 1'b0, 4'b1001, 2'b00, 2'b00, 4);
    addv("srli",  7'b0010011, 3'b101, 7'b0000000, 1'b0, 4'b0101, 2'b00, 2'b00, 4);
    addv("xori",  7'b0010011, 3'b100, 7'b1111111, 1'b0, 4'b0011, 2'b00, 2'b00, 4);
    addv("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b0, 4'b0010, 2'b01, 2'b00, 5);
    addv("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b0, 4'b0010, 2'b00, 2'b00, 4);
    addv("beq_t", 7'b1100011, 3'b000, 7'b0000000, 1'b1, 4'b0110, 2'b00, 2'b01, 3);
    addv("bne_n", 7'b1100011, 3'b001, 7'b0000000, 1'b0, 4'b0110, 2'b00, 2'b00, 3);
    addv("jal",   7'b1101111, 3'b000, 7'b0000000, 1'b0, 4'b0010, 2'b10, 2'b10, 4);
    addv("jalr",  7'b1100111, 3'b000, 7'b0000000, 1'b0, 4'b0010, 2'b10, 2'b10, 4);
    addv("lui",   7'b0110111, 3'b000, 7'b0000000, 1'b0, 4'b0010, 2'b11, 2'b00, 4);
    addv("auipc", 7'b0010111, 3'b000, 7'b0000000, 1'b0, 4'b0010, 2'b00, 2'b00, 4);

    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; m_instret = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_instret = '0;

    // Reset state: FETCH with a PC request outstanding.
    cyc("reset_state", 1'b0, 1'b0, fetch_exp(1'b0), a);
    do_reset();

    // Table vectors, zero-wait memory.
    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].tk, 0, 0,
                n, ra, rw, rp);
      chk({vecs[i].name, "_cycles"}, n, vecs[i].ncyc);
      chk({vecs[i].name, "_alu"}, int'(ra), int'(vecs[i].alu));
      chk({vecs[i].name, "_wb_sel"}, int'(rw), int'(vecs[i].wb));
      chk({vecs[i].name, "_pc_src"}, int'(rp), int'(vecs[i].pc));
    end
    chk("table_instret", int'(instret), vecs.size() % (1 << CW));

    // Store with memory ready delayed three cycles.
    run_instr("sw_wait3", 7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 3, n, ra, rw, rp);
    chk("sw_wait3_cycles", n, 7);

    // Memory ready exactly on the timeout cycle wins in both FETCH and MEM.
    run_instr("lw_edge", 7'b0000011, 3'b010, 7'b0000000, 1'b0, 4, 4, n, ra, rw, rp);
    chk("lw_edge_cycles", n, 13);

    // Illegal instructions trap, freeze instret, and clear on reset.
    run_instr("ill_op", 7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0, n, ra, rw, rp);
    expect_trap("ill_op_trap", 2'b01, 3);
    do_reset();
    cyc("post_reset", 1'b0, 1'b0, fetch_exp(1'b0), a);
    do_reset();
    run_instr("ill_f7", 7'b0110011, 3'b000, 7'b0000001, 1'b0, 1, 0, n, ra, rw, rp);
    expect_trap("ill_f7_trap", 2'b01, 2);
    do_reset();
    run_instr("ill_alt_f3", 7'b0110011, 3'b001, 7'b0100000, 1'b0, 0, 0, n, ra, rw, rp);
    expect_trap("ill_alt_trap", 2'b01, 2);
    do_reset();

    // FETCH timeout: five waiting cycles then TRAP cause 10.
    run_instr("pre_to", 7'b0010011, 3'b000, 7'b0000000, 1'b0, 0, 0, n, ra, rw, rp);
    for (int k = 0; k < 5; k++) begin
      opcode = 7'($urandom);
      cyc("fetch_wait", 1'b0, 1'($urandom), fetch_exp(1'b0), a);
    end
    expect_trap("fetch_timeout", 2'b10, 2);
    do_reset();

    // MEM timeout on a load.
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
    cyc("memto_fetch", 1'b1, 1'b0, fetch_exp(1'b1), a);
    cyc("memto_decode", 1'b0, 1'b0, decode_exp(), a);
    cyc("memto_exec", 1'b0, 1'b0, exec_exp(C_LD, 3'b010, 7'b0, 1'b0), a);
    for (int k = 0; k < 5; k++) cyc("memto_wait", 1'b0, 1'b0, mem_exp(C_LD, 1'b0), a);
    expect_trap("mem_timeout", 2'b10, 2);
    do_reset();

    // Reset wins over a completing FETCH handshake.
    run_instr("pre_rst", 7'b0010011, 3'b000, 7'b0000000, 1'b0, 0, 0, n, ra, rw, rp);
    opcode = 7'b0010011;
    cyc("pre_rst_wait", 1'b0, 1'b0, fetch_exp(1'b0), a);
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_instret = '0;
    run_instr("after_rst", 7'b0010011, 3'b000, 7'b0000000, 1'b0, 0, 0, n, ra, rw, rp);
    chk("after_rst_cycles", n, 4);

    // Randomized legal instruction stream with random wait states; instret wraps.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      op = legal_ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      if (op == 7'b0110011)
        f7 = ($urandom_range(0, 1) == 1 && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0;
      else if ($urandom_range(0, 3) == 0)
        f7 = 7'b0100000;
      run_instr("rand", op, f3, f7, 1'($urandom), $urandom_range(0, TMO),
                $urandom_range(0, TMO), n, ra, rw, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
